// File: rtl/gobang_pkg.sv
// Shared board constants, cell/side codes and the write-sequencer state encoding.
package gobang_pkg;

  localparam int unsigned BOARD_SIZE = 15;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  localparam logic BLACK = 1'b0;
  localparam logic WHITE = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StCheck,
    StWrite,
    StUndoRd,
    StUndoWr,
    StDone
  } seq_state_e;

  function automatic logic [1:0] side_to_cell(input logic side);
    return (side == WHITE) ? CELL_WHITE : CELL_BLACK;
  endfunction

endpackage

// File: rtl/move_stack.sv
// LIFO of placed moves, each entry {side, i, j}; top is the most recent push.
module move_stack #(
  parameter int unsigned DEPTH = 225,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned W     = 9
) (
  input  logic             clk_slow,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     push_data,
  output logic [W-1:0]     top,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [W-1:0]     mem [DEPTH];
  logic [CNT_W-1:0] count_q;

  assign count = count_q;
  assign full  = (count_q == LAST);
  assign empty = (count_q == '0);
  assign top   = empty ? '0 : mem[count_q - ONE];

  always_ff @(posedge clk_slow or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (push && !full) begin
      count_q <= count_q + ONE;
    end else if (pop && !empty) begin
      count_q <= count_q - ONE;
    end
  end

  // Storage carries no reset; the count alone defines which entries are live.
  always_ff @(posedge clk_slow) begin
    if (push && !full && !clr) begin
      mem[count_q] <= push_data;
    end
  end

endmodule

// File: rtl/board_write_sequencer.sv
// Owns the board write port: clear, place and undo with move history.
// Define UNDO_PAIR_EN to make one undo erase up to two moves.
module board_write_sequencer #(
  parameter int unsigned BOARD_SIZE = gobang_pkg::BOARD_SIZE,
  parameter int unsigned DEPTH      = 225,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk_slow,
  input  logic             rst,
  input  logic             clr_req,
  input  logic             place_req,
  input  logic [3:0]       place_i,
  input  logic [3:0]       place_j,
  input  logic             place_side,
  input  logic             undo_req,
  input  logic             cell_occupied,
  output logic             busy,
  output logic             clr_ack,
  output logic             place_ack,
  output logic             place_nack,
  output logic             undo_ack,
  output logic             undo_nack,
  output logic [3:0]       undo_i,
  output logic [3:0]       undo_j,
  output logic             undo_side,
  output logic [CNT_W-1:0] move_count,
  output logic             data_clr,
  output logic             data_write,
  output logic [3:0]       data_i,
  output logic [3:0]       data_j,
  output logic [1:0]       data_val
);
  import gobang_pkg::*;

  localparam logic [3:0]       OFF_BOARD = 4'(BOARD_SIZE);
  localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);
`ifdef UNDO_PAIR_EN
  localparam bit PAIR_EN = 1'b1;
`else
  localparam bit PAIR_EN = 1'b0;
`endif

  seq_state_e       state_q;
  logic [3:0]       pi_q, pj_q;
  logic             pside_q;
  logic             pair_q;
  logic [8:0]       stk_top;
  logic [CNT_W-1:0] stk_count;
  logic             stk_full, stk_empty;

  move_stack #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .W     (9)
  ) u_stack (
    .clk_slow  (clk_slow),
    .rst       (rst),
    .clr       (state_q == StClear),
    .push      (state_q == StWrite),
    .pop       (state_q == StUndoWr),
    .push_data ({pside_q, pi_q, pj_q}),
    .top       (stk_top),
    .count     (stk_count),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  assign move_count = stk_count;

  always_ff @(posedge clk_slow or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      busy       <= 1'b0;
      clr_ack    <= 1'b0;
      place_ack  <= 1'b0;
      place_nack <= 1'b0;
      undo_ack   <= 1'b0;
      undo_nack  <= 1'b0;
      undo_i     <= '0;
      undo_j     <= '0;
      undo_side  <= BLACK;
      data_clr   <= 1'b0;
      data_write <= 1'b0;
      data_i     <= OFF_BOARD;
      data_j     <= OFF_BOARD;
      data_val   <= CELL_EMPTY;
      pi_q       <= '0;
      pj_q       <= '0;
      pside_q    <= 1'b0;
      pair_q     <= 1'b0;
    end else begin
      // Strobes and handshakes are single-cycle unless re-asserted below.
      data_clr   <= 1'b0;
      data_write <= 1'b0;
      clr_ack    <= 1'b0;
      place_ack  <= 1'b0;
      place_nack <= 1'b0;
      undo_ack   <= 1'b0;
      undo_nack  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (clr_req) begin
            state_q  <= StClear;
            busy     <= 1'b1;
            data_clr <= 1'b1;
          end else if (undo_req) begin
            if (stk_empty) begin
              undo_nack <= 1'b1;
            end else begin
              state_q <= StUndoRd;
              busy    <= 1'b1;
              pair_q  <= PAIR_EN && (stk_count >= TWO);
            end
          end else if (place_req) begin
            pi_q    <= place_i;
            pj_q    <= place_j;
            pside_q <= place_side;
            data_i  <= place_i;
            data_j  <= place_j;
            state_q <= StCheck;
            busy    <= 1'b1;
          end
        end
        StClear: begin
          state_q <= StDone;
          clr_ack <= 1'b1;
        end
        StCheck: begin
          if (pi_q >= OFF_BOARD || pj_q >= OFF_BOARD || cell_occupied || stk_full) begin
            place_nack <= 1'b1;
            state_q    <= StIdle;
            busy       <= 1'b0;
          end else begin
            data_write <= 1'b1;
            data_val   <= side_to_cell(pside_q);
            state_q    <= StWrite;
          end
        end
        StWrite: begin
          place_ack <= 1'b1;
          state_q   <= StDone;
        end
        StUndoRd: begin
          {undo_side, undo_i, undo_j} <= stk_top;
          data_i     <= stk_top[7:4];
          data_j     <= stk_top[3:0];
          data_write <= 1'b1;
          data_val   <= CELL_EMPTY;
          state_q    <= StUndoWr;
        end
        StUndoWr: begin
          if (pair_q) begin
            pair_q  <= 1'b0;
            state_q <= StUndoRd;
          end else begin
            undo_ack <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_write_sequencer.sv
// Scoreboard bench: a move-history model predicts strobes and handshakes; a monitor checks them.
module tb_board_write_sequencer;

  localparam int BS    = 15;
  localparam int DEPTH = 225;
`ifdef UNDO_PAIR_EN
  localparam bit PAIR = 1'b1;
`else
  localparam bit PAIR = 1'b0;
`endif

  logic       clk_slow = 1'b0;
  logic       rst = 1'b0;
  logic       clr_req = 1'b0, place_req = 1'b0, undo_req = 1'b0;
  logic [3:0] place_i = '0, place_j = '0;
  logic       place_side = 1'b0;
  logic       cell_occupied;
  logic       busy, clr_ack, place_ack, place_nack, undo_ack, undo_nack;
  logic [3:0] undo_i, undo_j;
  logic       undo_side;
  logic [7:0] move_count;
  logic       data_clr, data_write;
  logic [3:0] data_i, data_j;
  logic [1:0] data_val;

  board_write_sequencer #(.BOARD_SIZE(15), .DEPTH(225), .CNT_W(8)) dut (
    .clk_slow(clk_slow), .rst(rst), .clr_req(clr_req), .place_req(place_req),
    .place_i(place_i), .place_j(place_j), .place_side(place_side), .undo_req(undo_req),
    .cell_occupied(cell_occupied), .busy(busy), .clr_ack(clr_ack), .place_ack(place_ack),
    .place_nack(place_nack), .undo_ack(undo_ack), .undo_nack(undo_nack), .undo_i(undo_i),
    .undo_j(undo_j), .undo_side(undo_side), .move_count(move_count), .data_clr(data_clr),
    .data_write(data_write), .data_i(data_i), .data_j(data_j), .data_val(data_val)
  );

  always #5 clk_slow = ~clk_slow;

  int cyc = 0;
  always @(posedge clk_slow) cyc <= cyc + 1;

  // Emulated board datapath, written only by the DUT's strobes.
  logic [1:0] dp [BS][BS];
  always @(posedge clk_slow) begin
    if (data_clr) begin
      for (int a = 0; a < BS; a++) for (int b = 0; b < BS; b++) dp[a][b] <= 2'b00;
    end else if (data_write && data_i < 4'd15 && data_j < 4'd15) begin
      dp[data_i][data_j] <= data_val;
    end
  end
  always_comb begin
    cell_occupied = 1'b0;
    if (data_i < 4'd15 && data_j < 4'd15) cell_occupied = (dp[data_i][data_j] != 2'b00);
  end

  typedef enum int {EvClr, EvWr, EvClrAck, EvPAck, EvPNack, EvUAck, EvUNack} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    int         cyc;
    logic [3:0] i;
    logic [3:0] j;
    logic [1:0] val;
    logic       side;
    int         cnt;
    logic       busy;
  } ev_t;
  typedef struct {logic [3:0] i; logic [3:0] j; logic side;} mv_t;

  ev_t        expq[$];
  mv_t        hist[$];
  logic [1:0] ref_board [BS][BS];
  int         checks = 0;
  int         failures = 0;

  function automatic ev_t mk(input ev_kind_e k, input int c, input logic [3:0] i,
                             input logic [3:0] j, input logic [1:0] v, input logic s,
                             input int n, input logic b);
    ev_t e;
    e.kind = k; e.cyc = c; e.i = i; e.j = j; e.val = v; e.side = s; e.cnt = n; e.busy = b;
    return e;
  endfunction

  task automatic mon_event(input ev_kind_e k);
    ev_t e;
    bit  ok;
    checks++;
    if (expq.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s: seen at cycle %0d, required none", k.name(), cyc);
      return;
    end
    e  = expq.pop_front();
    ok = (e.kind == k) && (e.cyc == cyc);
    case (k)
      EvWr:   ok = ok && data_i == e.i && data_j == e.j && data_val == e.val;
      EvUAck: ok = ok && undo_i == e.i && undo_j == e.j && undo_side == e.side
                   && move_count == 8'(e.cnt) && busy == e.busy;
      EvClrAck, EvPAck, EvPNack, EvUNack: ok = ok && move_count == 8'(e.cnt) && busy == e.busy;
      default: ;
    endcase
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %s cyc=%0d i=%0d j=%0d val=%0d side=%0d cnt=%0d busy=%0d ui=%0d uj=%0d; required %s cyc=%0d i=%0d j=%0d val=%0d side=%0d cnt=%0d busy=%0d",
               e.kind.name(), k.name(), cyc, data_i, data_j, data_val, undo_side, move_count,
               busy, undo_i, undo_j, e.kind.name(), e.cyc, e.i, e.j, e.val, e.side, e.cnt,
               e.busy);
    end
  endtask

  always @(negedge clk_slow) begin
    if (data_clr || data_write) begin
      checks++;
      if (data_clr && data_write) begin
        failures++;
        $display("FAIL strobe_overlap: data_clr=1 data_write=1, required not both");
      end
    end
    if (data_clr)   mon_event(EvClr);
    if (data_write) mon_event(EvWr);
    if (clr_ack)    mon_event(EvClrAck);
    if (place_ack)  mon_event(EvPAck);
    if (place_nack) mon_event(EvPNack);
    if (undo_ack)   mon_event(EvUAck);
    if (undo_nack)  mon_event(EvUNack);
  end

  task automatic check_reset(input string tag);
    checks++;
    if ({data_clr, data_write, clr_ack, place_ack, place_nack, undo_ack, undo_nack, busy} !== 8'h0) begin
      failures++;
      $display("FAIL %s_ctrl: strobes/acks/busy=%b, required 00000000", tag,
               {data_clr, data_write, clr_ack, place_ack, place_nack, undo_ack, undo_nack, busy});
    end
    checks++;
    if (data_i !== 4'd15 || data_j !== 4'd15 || data_val !== 2'b00) begin
      failures++;
      $display("FAIL %s_addr: data_i=%0d data_j=%0d data_val=%0d, required 15 15 0", tag,
               data_i, data_j, data_val);
    end
    checks++;
    if (move_count !== 8'd0 || {undo_i, undo_j, undo_side} !== 9'h0) begin
      failures++;
      $display("FAIL %s_regs: move_count=%0d undo=%0d/%0d/%0d, required 0 0/0/0", tag,
               move_count, undo_i, undo_j, undo_side);
    end
  endtask

  task automatic start_op(input string tag);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_busy: busy=%0d, required 0", tag, busy);
    end
  endtask

  task automatic wait_resp(input string tag);
    bit got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk_slow);
      got = clr_ack | place_ack | place_nack | undo_ack | undo_nack;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no ack/nack in 40 cycles, required one", tag);
    end
    clr_req = 1'b0; place_req = 1'b0; undo_req = 1'b0;
    @(negedge clk_slow);
  endtask

  task automatic do_clear();
    int n;
    start_op("clear");
    n = cyc;
    expq.push_back(mk(EvClr, n + 1, '0, '0, 2'b00, 1'b0, 0, 1'b1));
    expq.push_back(mk(EvClrAck, n + 2, '0, '0, 2'b00, 1'b0, 0, 1'b1));
    hist.delete();
    for (int a = 0; a < BS; a++) for (int b = 0; b < BS; b++) ref_board[a][b] = 2'b00;
    clr_req = 1'b1;
    wait_resp("clear");
  endtask

  task automatic do_place(input logic [3:0] i, input logic [3:0] j, input logic s);
    int n;
    bit rej;
    mv_t m;
    start_op("place");
    n = cyc;
    rej = (i >= 4'(BS)) || (j >= 4'(BS)) || (hist.size() == DEPTH);
    if (!rej) rej = (ref_board[i][j] != 2'b00);
    if (rej) begin
      expq.push_back(mk(EvPNack, n + 2, '0, '0, 2'b00, 1'b0, hist.size(), 1'b0));
    end else begin
      m.i = i; m.j = j; m.side = s;
      hist.push_back(m);
      ref_board[i][j] = s ? 2'b10 : 2'b01;
      expq.push_back(mk(EvWr, n + 2, i, j, ref_board[i][j], 1'b0, 0, 1'b1));
      expq.push_back(mk(EvPAck, n + 3, '0, '0, 2'b00, 1'b0, hist.size(), 1'b1));
    end
    place_i = i; place_j = j; place_side = s; place_req = 1'b1;
    wait_resp("place");
  endtask

  task automatic do_undo();
    int  n, npop;
    mv_t m;
    start_op("undo");
    n = cyc;
    if (hist.size() == 0) begin
      expq.push_back(mk(EvUNack, n + 1, '0, '0, 2'b00, 1'b0, 0, 1'b0));
    end else begin
      npop = (PAIR && hist.size() >= 2) ? 2 : 1;
      for (int k = 0; k < npop; k++) begin
        m = hist.pop_back();
        ref_board[m.i][m.j] = 2'b00;
        expq.push_back(mk(EvWr, n + 2 + 2 * k, m.i, m.j, 2'b00, 1'b0, 0, 1'b1));
      end
      expq.push_back(mk(EvUAck, n + 1 + 2 * npop, m.i, m.j, 2'b00, m.side, hist.size(), 1'b1));
    end
    undo_req = 1'b1;
    wait_resp("undo");
  endtask

  initial begin
    int n, bad;
    bit pending;
    repeat (3) @(negedge clk_slow);
    check_reset("reset");
    rst = 1'b1;
    @(negedge clk_slow);

    do_undo();                                  // empty history -> nack
    do_clear();
    do_place(4'd7, 4'd7, 1'b0);
    do_place(4'd7, 4'd7, 1'b1);                 // occupied
    do_place(4'd15, 4'd3, 1'b0);                // off-board row
    do_place(4'd4, 4'd15, 1'b1);                // off-board column
    do_place(4'd2, 4'd3, 1'b1);
    do_place(4'd9, 4'd9, 1'b0);
    repeat (4) do_undo();

    // Simultaneous requests: clear wins, undo and place follow while still held.
    do_place(4'd1, 4'd1, 1'b0);
    start_op("multi");
    n = cyc;
    expq.push_back(mk(EvClr, n + 1, '0, '0, 2'b00, 1'b0, 0, 1'b1));
    expq.push_back(mk(EvClrAck, n + 2, '0, '0, 2'b00, 1'b0, 0, 1'b1));
    expq.push_back(mk(EvUNack, n + 4, '0, '0, 2'b00, 1'b0, 0, 1'b0));
    expq.push_back(mk(EvWr, n + 6, 4'd5, 4'd6, 2'b10, 1'b0, 0, 1'b1));
    expq.push_back(mk(EvPAck, n + 7, '0, '0, 2'b00, 1'b0, 1, 1'b1));
    hist.delete();
    for (int a = 0; a < BS; a++) for (int b = 0; b < BS; b++) ref_board[a][b] = 2'b00;
    begin
      mv_t m;
      m.i = 4'd5; m.j = 4'd6; m.side = 1'b1;
      hist.push_back(m);
      ref_board[5][6] = 2'b10;
    end
    clr_req = 1'b1; undo_req = 1'b1;
    place_i = 4'd5; place_j = 4'd6; place_side = 1'b1; place_req = 1'b1;
    pending = 1'b1;
    for (int k = 0; k < 40 && pending; k++) begin
      @(negedge clk_slow);
      if (clr_ack) clr_req = 1'b0;
      if (undo_ack || undo_nack) undo_req = 1'b0;
      if (place_ack || place_nack) place_req = 1'b0;
      pending = clr_req | undo_req | place_req;
    end
    if (pending) begin
      checks++;
      failures++;
      $display("FAIL multi_timeout: requests still pending, required all serviced");
      clr_req = 1'b0; undo_req = 1'b0; place_req = 1'b0;
    end
    @(negedge clk_slow);

    for (int t = 0; t < 250; t++) begin
      int r;
      r = $urandom_range(99);
      if (r < 4) do_clear();
      else if (r < 34) do_undo();
      else do_place(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
    end

    do_clear();
    for (int a = 0; a < BS; a++)
      for (int b = 0; b < BS; b++) do_place(4'(a), 4'(b), 1'($urandom_range(1)));
    do_place(4'd0, 4'd0, 1'b0);                 // full history
    do_place(4'd14, 4'd14, 1'b1);
    do_undo();

    // Reset while the stone write strobe is up.
    do_clear();
    start_op("rst_write");
    n = cyc;
    expq.push_back(mk(EvWr, n + 2, 4'd3, 4'd4, 2'b10, 1'b0, 0, 1'b1));
    place_i = 4'd3; place_j = 4'd4; place_side = 1'b1; place_req = 1'b1;
    repeat (2) @(negedge clk_slow);
    #2 rst = 1'b0; place_req = 1'b0;
    #1 check_reset("mid_write");
    hist.delete();
    repeat (3) @(negedge clk_slow);
    rst = 1'b1;
    @(negedge clk_slow);
    checks++;
    if (dp[3][4] !== 2'b00) begin
      failures++;
      $display("FAIL rst_no_write: cell(3,4)=%0d, required 0", dp[3][4]);
    end
    do_undo();                                  // history lost -> nack
    do_clear();
    do_place(4'd8, 4'd8, 1'b1);
    do_place(4'd0, 4'd14, 1'b0);
    do_undo();
    repeat (3) @(negedge clk_slow);

    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL pending_events: %0d expected events unseen, required 0", expq.size());
    end
    checks++;
    if (move_count != 8'(hist.size())) begin
      failures++;
      $display("FAIL final_count: move_count=%0d, required %0d", move_count, hist.size());
    end
    bad = 0;
    for (int a = 0; a < BS; a++)
      for (int b = 0; b < BS; b++) if (dp[a][b] !== ref_board[a][b]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL final_board: %0d cells differ from model, required 0", bad);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
